gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable self-test driver and checker for the two-input, one-output gate blocks in the exercise set (`and_gate` and its siblings).

- **Drive side:** applies all four input combinations to the gate under test, waits a settle window, then samples `out1`.
- **Check side:** compares each sample against a parameterized truth table and reports pass/fail, a mismatch count and the failing vectors.
- **Placement:** sits on the FPGA next to the gate instance. It replaces the simulation-only stimulus/monitor with hardware that drives `in1`/`in2` and checks `out1`.

## Interface
Parameters:
- `SETTLE_CYCLES`, 3: cycles each vector is held before `out1` is sampled; legal range 1..255.
- `TRUTH`, 4'b1000: expected `out1` per vector; bit index v = {in1,in2}. The default is AND.
- `PASSES`, 1: number of full 4-vector sweeps per run; legal range 1..63.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request, sampled on the clock edge.
- `in1`  out  1  drive to gate under test (registered).
- `in2`  out  1  drive to gate under test (registered).
- `out1`  in  1  response from gate under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  1 when the last completed run had zero mismatches; held until the next accepted start.
- `err_count`  out  8  mismatch count for the current/last run; saturates at 255.
- `fail_vec`  out  4  sticky mask; bit v is set if vector v mismatched at least once this run.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **Reset (`rst_n` = 0 at an edge):**
  - State goes to IDLE.
  - `in1`, `in2`, `busy`, `done`, `pass` = 0.
  - `err_count` = 0, `fail_vec` = 0.
  - Internal vector index, pass counter and settle counter = 0.
  - Reset takes precedence over every other input.
- **IDLE or DONE with `start` = 1 (the accept edge):**
  - State goes to RUN; `busy` = 1.
  - `err_count`, `fail_vec` and `pass` are cleared.
  - Vector index = 0, so {in1,in2} = 00.
  - Settle counter = `SETTLE_CYCLES`-1; pass counter = 0.
- **RUN:**
  - On each edge where the settle counter ≠ 0, decrement it.
  - On an edge where the settle counter = 0 (the sample edge):
    - Compare `out1` against `TRUTH[v]`.
    - On mismatch: increment `err_count` (saturating at 255) and set `fail_vec[v]`.
    - Advance v (wrapping 3→0) and drive the new {in1,in2}.
    - Reload the settle counter with `SETTLE_CYCLES`-1.
    - When v wraps, increment the pass counter.
- **Final sample edge** (v = 3 and pass counter = `PASSES`-1):
  - Apply the comparison as above.
  - State goes to DONE.
  - `busy` = 0; `done` = 1 for exactly one cycle.
  - `pass` = 1 if the final `err_count` (including this sample) is 0, else 0.
  - `in1` = `in2` = 0.
- **DONE:** results are held; `done` deasserts after one cycle.
- **`start` while in RUN:** ignored; it has no effect on timing or results.
- **Same-edge comparison and drive:** the comparison on a sample edge uses the vector being retired, never the newly driven vector.

## Timing
- Accept edge E0 → vector 0 is visible on `in1`/`in2` in the cycle after E0.
- Sample edges fall at E0 + k·`SETTLE_CYCLES`, for k = 1 .. 4·`PASSES`.
- Each vector is held for exactly `SETTLE_CYCLES` cycles.
- `done` is high in the cycle following edge E0 + 4·`PASSES`·`SETTLE_CYCLES`.
- `busy` is high over the same span, from after E0 through that final edge.
- `out1` is sampled with no input synchronizer. The gate under test is combinational and on the same clock.
- A back-to-back run is possible: `start` asserted in the `done` cycle is accepted at that edge.
- `rst_n` low mid-run aborts the run. All outputs are 0 after that edge, and no `done` pulse is produced.

## Test plan
- **Correct AND gate, defaults:** `start` at E0 → {in1,in2} sequence 00, 01, 10, 11, each held 3 cycles. Expect `done` in the cycle after E0+12, `pass` = 1, `err_count` = 0, `fail_vec` = 0000.
- **OR gate as DUT, defaults:** expect `pass` = 0, `err_count` = 2, `fail_vec` = 0110.
- **`out1` stuck at 1, `PASSES` = 3:** expect `err_count` = 9, `fail_vec` = 0111, `done` after E0+36.
- **`start` pulsed while busy:**
  - Mid-run pulse at E0+5 → `done` time unchanged (after E0+12).
  - A second `start` in the DONE state → `err_count`/`fail_vec`/`pass` cleared at the accept edge, and the run repeats.
- **`rst_n` low for one edge during vector 2:** expect `in1`/`in2`/`busy`/`err_count`/`fail_vec` = 0 after that edge and no `done`. A later `start` completes with `pass` = 1.
- **`SETTLE_CYCLES` = 1, `TRUTH` = 4'b0110, XOR gate DUT:** vector changes every cycle. Expect `done` after E0+4 and `pass` = 1.

Source files
------------

// File: rtl/gate_bist.sv
// gate_bist: hardware self-test driver and checker for a two-input, one-output gate
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      run request; accepted in IDLE or DONE, ignored while busy
//   in1, in2   registered vector driven to the gate, {in1,in2} = vector index
//   out1       gate response, sampled once per vector at the end of its settle window
//   busy       high while a run is in progress
//   done       one-cycle pulse when a run completes
//   pass       last completed run had zero mismatches
//   err_count  saturating mismatch count of the current/last run
//   fail_vec   sticky per-vector mismatch mask of the current/last run
module gate_bist #(
    parameter int         SETTLE_CYCLES = 3,
    parameter logic [3:0] TRUTH         = 4'b1000,
    parameter int         PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    input  logic       out1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [7:0] SLOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [5:0] PLAST = 6'(PASSES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] v_q, v_d;
    logic [5:0] pcnt_q, pcnt_d;
    logic [7:0] scnt_q, scnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       miss, last;
    logic [7:0] err_inc;

    // The comparison always uses v_q, the vector being retired on this edge.
    assign miss    = out1 != TRUTH[v_q];
    assign last    = (v_q == 2'd3) && (pcnt_q == PLAST);
    assign err_inc = (miss && err_q != 8'hff) ? err_q + 8'd1 : err_q;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
                err_d   = 8'd0;
                fail_d  = 4'd0;
                v_d     = 2'd0;
                pcnt_d  = 6'd0;
                scnt_d  = SLOAD;
            end
        end else if (scnt_q != 8'd0) begin
            scnt_d = scnt_q - 8'd1;
        end else begin
            err_d  = err_inc;
            fail_d = fail_q | (miss ? 4'b0001 << v_q : 4'b0000);
            v_d    = v_q + 2'd1;
            scnt_d = SLOAD;
            pcnt_d = (v_q == 2'd3) ? pcnt_q + 6'd1 : pcnt_q;
            if (last) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = err_inc == 8'd0;
                v_d     = 2'd0;
                pcnt_d  = 6'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= 2'd0;
            pcnt_q  <= 6'd0;
            scnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign in1       = v_q[1];
    assign in2       = v_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed and randomized runs of three gate_bist configurations against gate models
module tb_gate_bist;
    localparam int         SC [3] = '{3, 3, 1};
    localparam int         PS [3] = '{1, 3, 1};
    localparam logic [3:0] TT [3] = '{4'b1000, 4'b1000, 4'b0110};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [3];
    logic       in1 [3];
    logic       in2 [3];
    logic       out1 [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [7:0] err [3];
    logic [3:0] fv [3];
    logic [3:0] g [3];
    int         checks = 0;
    int         fails = 0;
    int         exp_e;
    logic [3:0] exp_m;

    always #5 clk = ~clk;

    gate_bist u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in1(in1[0]), .in2(in2[0]), .out1(out1[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]), .fail_vec(fv[0])
    );
    gate_bist #(.PASSES(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in1(in1[1]), .in2(in2[1]), .out1(out1[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]), .fail_vec(fv[1])
    );
    gate_bist #(.SETTLE_CYCLES(1), .TRUTH(4'b0110)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in1(in1[2]), .in2(in2[2]), .out1(out1[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]), .fail_vec(fv[2])
    );

    // Combinational gate models: g[k] is the gate's truth table indexed by {in1,in2}.
    assign out1[0] = g[0][{in1[0], in2[0]}];
    assign out1[1] = g[1][{in1[1], in2[1]}];
    assign out1[2] = g[2][{in1[2], in2[2]}];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One run on instance k; a start pulse is injected before edge E0+mid (0 = none).
    // Returns in the done cycle with the results checked.
    task automatic run(input int k, input int mid);
        int n;
        n = 4 * SC[k] * PS[k];
        exp_m = g[k] ^ TT[k];
        exp_e = $countones(exp_m) * PS[k];
        if (exp_e > 255) exp_e = 255;
        start[k] = 1'b1;
        tick;
        start[k] = 1'b0;
        chk("acc_err", 32'(err[k]), 0);
        chk("acc_fv", 32'(fv[k]), 0);
        chk("acc_pass", 32'(pass[k]), 0);
        for (int j = 1; j <= n; j++) begin
            chk("vec", 32'({in1[k], in2[k]}), 32'(((j - 1) / SC[k]) % 4));
            chk("busy", 32'(busy[k]), 1);
            chk("done_early", 32'(done[k]), 0);
            if (j == mid) start[k] = 1'b1;
            tick;
            start[k] = 1'b0;
        end
        chk("done", 32'(done[k]), 1);
        chk("busy_end", 32'(busy[k]), 0);
        chk("vec_end", 32'({in1[k], in2[k]}), 0);
        chk("pass", 32'(pass[k]), 32'(exp_e == 0));
        chk("err", 32'(err[k]), 32'(exp_e));
        chk("fv", 32'(fv[k]), 32'(exp_m));
    endtask

    task automatic hold(input int k);
        tick;
        chk("done_pulse", 32'(done[k]), 0);
        chk("hold_busy", 32'(busy[k]), 0);
        chk("hold_err", 32'(err[k]), 32'(exp_e));
        chk("hold_fv", 32'(fv[k]), 32'(exp_m));
        chk("hold_pass", 32'(pass[k]), 32'(exp_e == 0));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        g[0] = 4'b1000;
        g[1] = 4'b1111;
        g[2] = 4'b0110;
        tick;
        tick;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in", 32'({in1[k], in2[k]}), 0);
            chk("rst_busy", 32'(busy[k]), 0);
            chk("rst_done", 32'(done[k]), 0);
            chk("rst_pass", 32'(pass[k]), 0);
            chk("rst_err", 32'(err[k]), 0);
            chk("rst_fv", 32'(fv[k]), 0);
        end
        rst_n = 1'b1;
        tick;
        run(0, 0);
        hold(0);
        g[0] = 4'b1110;
        run(0, 5);
        g[0] = 4'b1000;
        run(0, 0);
        hold(0);
        run(1, 0);
        hold(1);
        run(2, 0);
        hold(2);
        g[0] = 4'b1110;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (6) tick;
        chk("abort_vec", 32'({in1[0], in2[0]}), 2);
        chk("abort_err_pre", 32'(err[0]), 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_in", 32'({in1[0], in2[0]}), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_err", 32'(err[0]), 0);
        chk("abort_fv", 32'(fv[0]), 0);
        chk("abort_pass", 32'(pass[0]), 0);
        for (int i = 0; i < 15; i++) begin
            chk("abort_done", 32'(done[0]), 0);
            tick;
        end
        g[0] = 4'b1000;
        run(0, 0);
        hold(0);
        for (int i = 0; i < 10; i++) begin
            int k;
            k = $urandom_range(0, 2);
            g[k] = 4'($urandom_range(0, 15));
            run(k, $urandom_range(0, 4 * SC[k] * PS[k]));
            if ($urandom_range(0, 1) == 1) hold(k);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
